// File: rtl/bf_insn_sequencer.sv
// bf_insn_sequencer: fetch/decode/execute sequencer with '['/']' loop scanning for the DekatronPC core.
// Optional single-step mode via SINGLE_STEP_EN (adds the Step port, one insn or loop jump per Step).
module bf_insn_sequencer #(
  parameter int DEPTH_W = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Run,
  output logic       InsnReq,
  input  logic       InsnAck,
  input  logic [3:0] Insn,
  output logic       IpInc,
  output logic       IpDec,
  output logic       ApInc,
  output logic       ApDec,
  output logic       DataInc,
  output logic       DataDec,
  input  logic       ExecDone,
  input  logic       DataZero,
  output logic       IoOutReq,
  output logic       IoInReq,
  input  logic       IoAck,
  output logic       Halted,
  output logic       Error
`ifdef SINGLE_STEP_EN
  ,
  input  logic       Step
`endif
);
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, EXEC, WAIT, ADVANCE, SEEK_FWD, SEEK_BACK, HALT, ERROR} state_t;
  state_t state_q, state_d;
  logic [3:0] insn_q, insn_d;
  logic [9:0] op_q, op_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic seek_q, seek_d, back_q, back_d;
  logic ip_inc, ip_dec, go, cont, up, dn, live;
`ifdef SINGLE_STEP_EN
  assign go = Run | Step;
  assign cont = 1'b0;
`else
  assign go = Run;
  assign cont = Run;
`endif
  // while scanning backwards the roles of '[' and ']' swap
  assign up = back_q ? insn_q == 4'd7 : insn_q == 4'd6;
  assign dn = back_q ? insn_q == 4'd6 : insn_q == 4'd7;
  always_comb begin
    state_d = state_q;
    insn_d = insn_q;
    op_d = op_q;
    depth_d = depth_q;
    seek_d = seek_q;
    back_d = back_q;
    ip_inc = 1'b0;
    ip_dec = 1'b0;
    case (state_q)
      IDLE: state_d = go ? FETCH : IDLE;
      FETCH: if (InsnAck) begin
        insn_d = Insn;
        state_d = !seek_q ? DECODE : back_q ? SEEK_BACK : SEEK_FWD;
      end
      DECODE: begin
        op_d = insn_q > 4'd9 ? 10'd1 : 10'd1 << insn_q;
        state_d = EXEC;
      end
      EXEC: begin
        if (op_q[1]) state_d = HALT;
        else if (|op_q[5:2]) state_d = ExecDone ? ADVANCE : WAIT;
        else if ((op_q[6] && DataZero) || (op_q[7] && !DataZero)) begin
          depth_d = DEPTH_W'(1);
          seek_d = 1'b1;
          back_d = op_q[7];
          ip_inc = op_q[6];
          ip_dec = op_q[7];
          state_d = FETCH;
        end
        else if (|op_q[9:8]) state_d = IoAck ? ADVANCE : EXEC;
        else state_d = ADVANCE;
      end
      WAIT: state_d = ExecDone ? ADVANCE : WAIT;
      ADVANCE: begin
        ip_inc = 1'b1;
        state_d = cont ? FETCH : IDLE;
      end
      SEEK_FWD, SEEK_BACK: begin
        depth_d = depth_q + DEPTH_W'(up) - DEPTH_W'(dn);
        if (up && &depth_q) state_d = ERROR;
        else if (depth_d == '0) begin
          seek_d = 1'b0;
          state_d = ADVANCE;
        end else begin
          ip_inc = !back_q;
          ip_dec = back_q;
          state_d = FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      insn_q <= '0;
      op_q <= '0;
      depth_q <= '0;
      seek_q <= 1'b0;
      back_q <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q <= insn_d;
      op_q <= op_d;
      depth_q <= depth_d;
      seek_q <= seek_d;
      back_q <= back_d;
    end
  end
  // reset drops every request and strobe in the cycle it is asserted
  assign live = !Rst;
  assign InsnReq = live && state_q == FETCH;
  assign IpInc = live && ip_inc;
  assign IpDec = live && ip_dec;
  assign DataInc = live && state_q == EXEC && op_q[2];
  assign DataDec = live && state_q == EXEC && op_q[3];
  assign ApInc = live && state_q == EXEC && op_q[4];
  assign ApDec = live && state_q == EXEC && op_q[5];
  assign IoOutReq = live && state_q == EXEC && op_q[8];
  assign IoInReq = live && state_q == EXEC && op_q[9];
  assign Halted = live && (state_q == HALT || state_q == ERROR);
  assign Error = live && state_q == ERROR;
endmodule

// File: tb/tb_bf_insn_sequencer.sv
// tb_bf_insn_sequencer: drives the sequencer with a small BF machine (memory, pointers, console)
// and compares it with a plain interpreter; a DEPTH_W=2 copy runs in lockstep for overflow.
module tb_bf_insn_sequencer;
  logic Clk = 1'b0;
  logic Rst = 1'b1, Run = 1'b0, InsnAck = 1'b0, ExecDone = 1'b0, DataZero = 1'b1, IoAck = 1'b0;
  logic [3:0] Insn = '0;
  logic InsnReq, IpInc, IpDec, ApInc, ApDec, DataInc, DataDec, IoOutReq, IoInReq, Halted, Error;
  logic [10:0] o2, outs;
  always #5 Clk = ~Clk;

  bf_insn_sequencer dut (.Clk(Clk), .Rst(Rst), .Run(Run), .InsnReq(InsnReq), .InsnAck(InsnAck), .Insn(Insn),
    .IpInc(IpInc), .IpDec(IpDec), .ApInc(ApInc), .ApDec(ApDec), .DataInc(DataInc), .DataDec(DataDec),
    .ExecDone(ExecDone), .DataZero(DataZero), .IoOutReq(IoOutReq), .IoInReq(IoInReq), .IoAck(IoAck),
    .Halted(Halted), .Error(Error));
  bf_insn_sequencer #(.DEPTH_W(2)) dut2 (.Clk(Clk), .Rst(Rst), .Run(Run), .InsnReq(o2[10]), .InsnAck(InsnAck),
    .Insn(Insn), .IpInc(o2[9]), .IpDec(o2[8]), .ApInc(o2[7]), .ApDec(o2[6]), .DataInc(o2[5]), .DataDec(o2[4]),
    .ExecDone(ExecDone), .DataZero(DataZero), .IoOutReq(o2[3]), .IoInReq(o2[2]), .IoAck(IoAck),
    .Halted(o2[1]), .Error(o2[0]));
  assign outs = {InsnReq, IpInc, IpDec, ApInc, ApDec, DataInc, DataDec, IoOutReq, IoInReq, Halted, Error};

  int total = 0, bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // environment: program store, data memory, pointers, console, latency-programmable responders
  logic [3:0] prog[64];
  logic [7:0] mem[256];
  logic [7:0] ap;
  logic [7:0] outq[$], inq[$], src_in[$];
  int ip, flat, elat, iolat, fcnt, ecnt, iocnt, cyc, viol;
  int n_ipinc, n_ipdec, n_apinc, n_apdec, n_dinc, n_ddec;
  int inc_cyc[$];
  bit epend, env_on = 1'b0;

  function automatic logic [3:0] code(input int a);
    return (a < 0 || a > 63) ? 4'd1 : prog[a];
  endfunction

  task automatic env_step();
    cyc++;
    if ($countones({IpInc, IpDec, ApInc, ApDec, DataInc, DataDec}) > 1) viol++;
    if (IpInc && epend) viol++;
    if (IpInc) begin ip++; n_ipinc++; inc_cyc.push_back(cyc); end
    if (IpDec) begin ip--; n_ipdec++; end
    if (ApInc) begin ap++; n_apinc++; end
    if (ApDec) begin ap--; n_apdec++; end
    if (DataInc) begin mem[ap]++; n_dinc++; end
    if (DataDec) begin mem[ap]--; n_ddec++; end
    if (ApInc | ApDec | DataInc | DataDec) begin epend = 1'b1; ecnt = 0; end
    InsnAck = 1'b0;
    ExecDone = 1'b0;
    IoAck = 1'b0;
    if (epend) begin
      if (ecnt == elat) begin ExecDone = 1'b1; epend = 1'b0; end
      else ecnt++;
    end
    if (InsnReq) begin
      if (fcnt == flat) begin InsnAck = 1'b1; Insn = code(ip); fcnt = 0; end
      else fcnt++;
    end
    if (IoOutReq | IoInReq) begin
      if (iocnt == iolat) begin
        IoAck = 1'b1;
        iocnt = 0;
        if (IoOutReq) outq.push_back(mem[ap]);
        else mem[ap] = inq.size() > 0 ? inq.pop_front() : 8'd0;
      end else iocnt++;
    end
    DataZero = mem[ap] == 8'd0;
  endtask

  initial forever begin
    @(negedge Clk);
    if (env_on) env_step();
  end

  task automatic load_prog(input logic [63:0] p);
    for (int i = 0; i < 64; i++) prog[i] = i < 16 ? p[4*i +: 4] : 4'd1;
  endtask

  task automatic start_run();
    env_on = 1'b0;
    Rst = 1'b1;
    Run = 1'b0;
    InsnAck = 1'b0; ExecDone = 1'b0; IoAck = 1'b0; Insn = '0; DataZero = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    ap = 8'd0; ip = 0; fcnt = 0; ecnt = 0; iocnt = 0; cyc = 0; viol = 0; epend = 1'b0;
    n_ipinc = 0; n_ipdec = 0; n_apinc = 0; n_apdec = 0; n_dinc = 0; n_ddec = 0;
    outq.delete(); inc_cyc.delete();
    inq = src_in;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    env_on = 1'b1;
    Run = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int c = 0;
    while (!Halted && c < budget) begin @(negedge Clk); c++; end
    chk("halt_reached", int'(Halted), 1);
    repeat (2) @(negedge Clk);
  endtask

  // reference interpreter: walks the program directly, matching brackets by scanning with a depth count
  logic [7:0] m_mem[256];
  logic [7:0] m_ap;
  logic [7:0] m_out[$], m_in[$];
  int m_ip, m_steps, m_inc, m_dec, m_apinc, m_apdec, m_dinc, m_ddec;
  bit m_halt, m_err;
  task automatic model(input int maxd, input int limit);
    int d;
    logic [3:0] c;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
    m_ap = 8'd0; m_ip = 0; m_steps = 0; m_inc = 0; m_dec = 0;
    m_apinc = 0; m_apdec = 0; m_dinc = 0; m_ddec = 0; m_halt = 0; m_err = 0;
    m_out.delete();
    m_in = src_in;
    while (!m_halt && !m_err && m_steps < limit) begin
      c = code(m_ip);
      m_steps++;
      case (c)
        4'd1: m_halt = 1;
        4'd2: begin m_mem[m_ap]++; m_dinc++; end
        4'd3: begin m_mem[m_ap]--; m_ddec++; end
        4'd4: begin m_ap++; m_apinc++; end
        4'd5: begin m_ap--; m_apdec++; end
        4'd6: if (m_mem[m_ap] == 0) begin
          d = 1;
          while (d > 0 && !m_err && m_steps < limit) begin
            m_ip++; m_inc++; m_steps++;
            c = code(m_ip);
            if (c == 4'd6) begin if (d == maxd) m_err = 1; else d++; end
            else if (c == 4'd7) d--;
          end
        end
        4'd7: if (m_mem[m_ap] != 0) begin
          d = 1;
          while (d > 0 && !m_err && m_steps < limit) begin
            m_ip--; m_dec++; m_steps++;
            c = code(m_ip);
            if (c == 4'd7) begin if (d == maxd) m_err = 1; else d++; end
            else if (c == 4'd6) d--;
          end
        end
        4'd8: m_out.push_back(m_mem[m_ap]);
        4'd9: m_mem[m_ap] = m_in.size() > 0 ? m_in.pop_front() : 8'd0;
        default: ;
      endcase
      if (!m_halt && !m_err) begin m_ip++; m_inc++; end
    end
  endtask

  task automatic gen_prog();
    int n, open, r;
    logic [3:0] plain[12] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd2, 4'd3, 4'd10, 4'd13, 4'd15};
    n = 0; open = 0;
    for (int i = 0; i < 64; i++) prog[i] = 4'd1;
    for (int k = $urandom_range(4, 24); k > 0 && n < 56; k--) begin
      r = $urandom_range(0, 9);
      if (r == 0 && open < 3) begin prog[n] = 4'd6; open++; end
      else if (r == 1 && open > 0) begin prog[n] = 4'd7; open--; end
      else prog[n] = plain[$urandom_range(0, 11)];
      n++;
    end
    for (; open > 0; open--) begin prog[n] = 4'd7; n++; end
  endtask

  typedef struct {
    logic [63:0] p;
    int flat, elat, iolat;
    logic [7:0] din;
    int dinc, ddec, apinc, ipinc, ipdec, nout;
    logic [7:0] mem0;
    int ip;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int diffs;
    vecs[0] = '{64'h1822, 0, 0, 0, 8'h00, 2, 0, 0, 3, 0, 1, 8'h02, 3};
    vecs[1] = '{64'h14737266, 1, 1, 1, 8'h00, 0, 0, 1, 7, 0, 0, 8'h00, 7};
    vecs[2] = '{64'h173622, 0, 2, 0, 8'h00, 2, 2, 0, 7, 2, 0, 8'h00, 5};
    vecs[3] = '{64'h14F2A, 0, 5, 0, 8'h00, 1, 0, 1, 4, 0, 0, 8'h01, 4};
    vecs[4] = '{64'h189, 0, 0, 2, 8'h5A, 0, 0, 0, 2, 0, 1, 8'h5A, 2};
    vecs[5] = '{64'h100, 3, 0, 0, 8'h00, 0, 0, 0, 2, 0, 0, 8'h00, 2};
    vecs[6] = '{64'h17362, 1, 1, 1, 8'h00, 1, 1, 0, 4, 0, 0, 8'h00, 4};
    vecs[7] = '{64'h13452, 2, 3, 1, 8'h00, 1, 1, 1, 4, 0, 0, 8'h00, 4};
    repeat (2) @(negedge Clk);
    #1 chk("reset_outs", int'(outs), 0);
    for (int i = 0; i < 8; i++) begin
      load_prog(vecs[i].p);
      flat = vecs[i].flat; elat = vecs[i].elat; iolat = vecs[i].iolat;
      src_in.delete(); src_in.push_back(vecs[i].din);
      start_run();
      wait_halt(2000);
      chk($sformatf("v%0d_dinc", i), n_dinc, vecs[i].dinc);
      chk($sformatf("v%0d_ddec", i), n_ddec, vecs[i].ddec);
      chk($sformatf("v%0d_apinc", i), n_apinc, vecs[i].apinc);
      chk($sformatf("v%0d_ipinc", i), n_ipinc, vecs[i].ipinc);
      chk($sformatf("v%0d_ipdec", i), n_ipdec, vecs[i].ipdec);
      chk($sformatf("v%0d_nout", i), outq.size(), vecs[i].nout);
      chk($sformatf("v%0d_mem0", i), int'(mem[0]), int'(vecs[i].mem0));
      chk($sformatf("v%0d_ip", i), ip, vecs[i].ip);
      chk($sformatf("v%0d_error", i), int'(Error), 0);
      chk($sformatf("v%0d_viol", i), viol, 0);
    end
    // NOP throughput and sticky halt
    load_prog(64'h1000); flat = 0; elat = 0; iolat = 0; src_in.delete();
    start_run();
    wait_halt(200);
    chk("nop_incs", inc_cyc.size(), 3);
    if (inc_cyc.size() >= 3) begin
      chk("nop_lat1", inc_cyc[1] - inc_cyc[0], 4);
      chk("nop_lat2", inc_cyc[2] - inc_cyc[1], 4);
    end
    repeat (10) @(negedge Clk);
    chk("halt_sticky", int'(Halted), 1);
    chk("halt_no_fetch", int'(InsnReq), 0);
    chk("halt_ip", ip, 3);
    // depth overflow on the DEPTH_W=2 copy while the wide copy completes the skip
    load_prog(64'h177776666);
    start_run();
    wait_halt(500);
    chk("ovf_wide_error", int'(Error), 0);
    chk("ovf_error", int'(o2[0]), 1);
    chk("ovf_halted", int'(o2[1]), 1);
    repeat (10) @(negedge Clk);
    chk("ovf_error_held", int'(o2[0]), 1);
    env_on = 1'b0; Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0; Run = 1'b0;
    #1 chk("ovf_cleared", int'(o2), 0);
    // Run dropped mid-seek: loop jump completes, then the core parks in IDLE
    load_prog(64'h14706);
    start_run();
    for (int c = 0; c < 20 && n_ipinc == 0; c++) @(negedge Clk);
    Run = 1'b0;
    repeat (30) @(negedge Clk);
    chk("stop_ip", ip, 3);
    chk("stop_apinc", n_apinc, 0);
    chk("stop_outs", int'(outs), 0);
    // reset while a fetch is outstanding, then a late ack
    load_prog(64'h1); flat = 1000;
    start_run();
    for (int c = 0; c < 10 && !InsnReq; c++) @(negedge Clk);
    chk("rst_req_up", int'(InsnReq), 1);
    env_on = 1'b0; Rst = 1'b1;
    #1 chk("rst_same_cycle", int'(InsnReq), 0);
    @(negedge Clk); Rst = 1'b0; Run = 1'b0;
    #1 chk("rst_outs", int'(outs), 0);
    InsnAck = 1'b1; Insn = 4'd2; ExecDone = 1'b1;
    @(negedge Clk); InsnAck = 1'b0; ExecDone = 1'b0;
    repeat (3) @(negedge Clk);
    chk("late_ack_ignored", int'(outs), 0);
    // reset while ExecDone is pending
    load_prog(64'h12); flat = 0; elat = 1000;
    start_run();
    for (int c = 0; c < 20 && n_dinc == 0; c++) @(negedge Clk);
    chk("pend_strobe", n_dinc, 1);
    @(negedge Clk);
    env_on = 1'b0; Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0; Run = 1'b0; ExecDone = 1'b1;
    @(negedge Clk); ExecDone = 1'b0;
    repeat (2) @(negedge Clk);
    chk("late_done_ignored", int'(outs), 0);
    // random programs against the interpreter
    for (int t = 0; t < 20; t++) begin
      int tries = 0;
      do begin
        gen_prog();
        src_in.delete();
        for (int k = 0; k < 4; k++) src_in.push_back(8'($urandom_range(0, 3)));
        model(255, 120);
        tries++;
      end while (!(m_halt || m_err) && tries < 50);
      flat = $urandom_range(0, 3); elat = $urandom_range(0, 3); iolat = $urandom_range(0, 3);
      start_run();
      wait_halt(m_steps * 16 + 100);
      chk($sformatf("r%0d_error", t), int'(Error), int'(m_err));
      chk($sformatf("r%0d_ip", t), ip, m_ip);
      chk($sformatf("r%0d_ap", t), int'(ap), int'(m_ap));
      chk($sformatf("r%0d_ipinc", t), n_ipinc, m_inc);
      chk($sformatf("r%0d_ipdec", t), n_ipdec, m_dec);
      chk($sformatf("r%0d_data", t), n_dinc * 1000 + n_ddec, m_dinc * 1000 + m_ddec);
      chk($sformatf("r%0d_apmoves", t), n_apinc * 1000 + n_apdec, m_apinc * 1000 + m_apdec);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] != m_mem[i]) diffs++;
      chk($sformatf("r%0d_mem", t), diffs, 0);
      chk($sformatf("r%0d_nout", t), outq.size(), m_out.size());
      diffs = 0;
      for (int i = 0; i < outq.size() && i < m_out.size(); i++) if (outq[i] != m_out[i]) diffs++;
      chk($sformatf("r%0d_outval", t), diffs, 0);
      chk($sformatf("r%0d_viol", t), viol, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
